// File: rtl/writeback_stage_pkg.sv
// Shared core constants for the writeback stage.
// Holds the data and register widths plus the load funct3 encodings.
package writeback_stage_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Load data formatter: lane extraction and sign/zero extension.
// Purely combinational; flags funct3 codes that are not loads.
module load_formatter
    import writeback_stage_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [2:0]   funct3,
    input  logic [1:0]   lsb,
    input  logic [W-1:0] raw,
    output logic [W-1:0] data,
    output logic         illegal
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = raw[{lsb, 3'b000} +: 8];
    assign half_v = lsb[1] ? raw[31:16] : raw[15:0];

    always_comb begin
        data    = '0;
        illegal = 1'b0;
        unique case (funct3)
            F3_LB:   data = {{(W-8){byte_v[7]}}, byte_v};
            F3_LH:   data = {{(W-16){half_v[15]}}, half_v};
            F3_LW:   data = raw;
            F3_LBU:  data = {{(W-8){1'b0}}, byte_v};
            F3_LHU:  data = {{(W-16){1'b0}}, half_v};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges MEM and MDU results into one register write.
// A 1-entry hold buffer defers an MDU result that collides with MEM.
module writeback_stage #(
    parameter int XLEN   = writeback_stage_pkg::XLEN,
    parameter int REG_AW = writeback_stage_pkg::REG_AW
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              mem_valid_in,
    input  logic              mem_reg_wr_in,
    input  logic              mem_is_load_in,
    input  logic [2:0]        mem_funct3_in,
    input  logic [1:0]        mem_addr_lsb_in,
    input  logic [REG_AW-1:0] mem_rd_addr_in,
    input  logic [XLEN-1:0]   mem_alu_result_in,
    input  logic [XLEN-1:0]   mem_load_data_in,
    input  logic              mdu_valid_in,
    input  logic [REG_AW-1:0] mdu_rd_addr_in,
    input  logic [XLEN-1:0]   mdu_result_in,
    output logic              mdu_ready_out,
    output logic              wb_stall_out,
    output logic [REG_AW-1:0] rd_addr_out,
    output logic [XLEN-1:0]   rd_out,
    output logic              wr_en_out,
    output logic              load_fault_out
);

    logic              hold_valid;
    logic [REG_AW-1:0] hold_rd;
    logic [XLEN-1:0]   hold_data;

    logic [XLEN-1:0]   fmt_data;
    logic              fmt_illegal;
    logic [XLEN-1:0]   mem_data;
    logic              mem_fault;

    logic              slot;
    logic              sel_wr;
    logic              sel_fault;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic              hold_load;

    load_formatter #(
        .W(XLEN)
    ) u_fmt (
        .funct3  (mem_funct3_in),
        .lsb     (mem_addr_lsb_in),
        .raw     (mem_load_data_in),
        .data    (fmt_data),
        .illegal (fmt_illegal)
    );

    assign mem_data  = mem_is_load_in ? fmt_data : mem_alu_result_in;
    assign mem_fault = mem_is_load_in & fmt_illegal;

    assign mdu_ready_out = !hold_valid;
    assign wb_stall_out  = hold_valid & mem_valid_in;

    always_comb begin
        slot      = 1'b0;
        sel_wr    = 1'b0;
        sel_fault = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        hold_load = 1'b0;
        if (hold_valid) begin
            slot     = 1'b1;
            sel_wr   = 1'b1;
            sel_rd   = hold_rd;
            sel_data = hold_data;
        end else if (mem_valid_in) begin
            slot      = 1'b1;
            sel_wr    = mem_reg_wr_in & !mem_fault;
            sel_fault = mem_fault;
            sel_rd    = mem_rd_addr_in;
            sel_data  = mem_data;
            // Younger MEM write to the same rd makes the MDU result dead.
            hold_load = mdu_valid_in &
                        !(mem_reg_wr_in &&
                          (mem_rd_addr_in == mdu_rd_addr_in));
        end else if (mdu_valid_in) begin
            slot     = 1'b1;
            sel_wr   = 1'b1;
            sel_rd   = mdu_rd_addr_in;
            sel_data = mdu_result_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en_out      <= 1'b0;
            load_fault_out <= 1'b0;
            rd_addr_out    <= '0;
            rd_out         <= '0;
            hold_valid     <= 1'b0;
            hold_rd        <= '0;
            hold_data      <= '0;
        end else begin
            wr_en_out      <= slot & sel_wr & (sel_rd != '0);
            load_fault_out <= sel_fault;
            if (slot) begin
                rd_addr_out <= sel_rd;
                rd_out      <= sel_data;
            end
            hold_valid <= hold_load;
            if (hold_load) begin
                hold_rd   <= mdu_rd_addr_in;
                hold_data <= mdu_result_in;
            end
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage against a behavioural model.
// Driver pushes expected per-cycle results; monitor pops and compares.
module tb_writeback_stage;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        mem_valid_in = 1'b0;
    logic        mem_reg_wr_in = 1'b0;
    logic        mem_is_load_in = 1'b0;
    logic [2:0]  mem_funct3_in = '0;
    logic [1:0]  mem_addr_lsb_in = '0;
    logic [4:0]  mem_rd_addr_in = '0;
    logic [31:0] mem_alu_result_in = '0;
    logic [31:0] mem_load_data_in = '0;
    logic        mdu_valid_in = 1'b0;
    logic [4:0]  mdu_rd_addr_in = '0;
    logic [31:0] mdu_result_in = '0;
    logic        mdu_ready_out;
    logic        wb_stall_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;
    logic        wr_en_out;
    logic        load_fault_out;

    writeback_stage dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .mem_valid_in      (mem_valid_in),
        .mem_reg_wr_in     (mem_reg_wr_in),
        .mem_is_load_in    (mem_is_load_in),
        .mem_funct3_in     (mem_funct3_in),
        .mem_addr_lsb_in   (mem_addr_lsb_in),
        .mem_rd_addr_in    (mem_rd_addr_in),
        .mem_alu_result_in (mem_alu_result_in),
        .mem_load_data_in  (mem_load_data_in),
        .mdu_valid_in      (mdu_valid_in),
        .mdu_rd_addr_in    (mdu_rd_addr_in),
        .mdu_result_in     (mdu_result_in),
        .mdu_ready_out     (mdu_ready_out),
        .wb_stall_out      (wb_stall_out),
        .rd_addr_out       (rd_addr_out),
        .rd_out            (rd_out),
        .wr_en_out         (wr_en_out),
        .load_fault_out    (load_fault_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit          wr;
        bit          fault;
        bit          chk;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    exp_t expq[$];
    ent_t held[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_comb = 0;

    function automatic logic [31:0] ref_load(
        input logic [2:0] f3, input logic [1:0] lsb,
        input logic [31:0] raw, output bit bad);
        logic [31:0] b, h;
        b = (raw >> (8 * lsb)) & 32'hFF;
        h = (raw >> (16 * lsb[1])) & 32'hFFFF;
        bad = 0;
        case (f3)
            3'd0: return (b >= 128) ? b - 32'd256 : b;
            3'd1: return (h >= 32768) ? h - 32'd65536 : h;
            3'd2: return raw;
            3'd4: return b;
            3'd5: return h;
            default: begin bad = 1; return 32'd0; end
        endcase
    endfunction

    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            n_chk++;
            if (wr_en_out !== e.wr || load_fault_out !== e.fault ||
                ((e.wr || e.chk) &&
                 (rd_addr_out !== e.rd || rd_out !== e.data))) begin
                n_fail++;
                $display("FAIL wb_out t=%0t: got wr=%b flt=%b rd=%0d d=%h, want wr=%b flt=%b rd=%0d d=%h",
                         $time, wr_en_out, load_fault_out, rd_addr_out,
                         rd_out, e.wr, e.fault, e.rd, e.data);
            end
        end
    end

    task automatic step();
        exp_t e;
        ent_t h;
        bit bad, mem_taken, mdu_taken;
        logic [31:0] d;
        e = '{wr: 0, fault: 0, chk: 0, rd: '0, data: '0};
        mem_taken = 0;
        mdu_taken = 0;
        #1;
        if (chk_comb) begin
            n_chk += 2;
            if (mdu_ready_out !== (held.size() == 0)) begin
                n_fail++;
                $display("FAIL mdu_ready t=%0t: got %b want %b",
                         $time, mdu_ready_out, held.size() == 0);
            end
            if (wb_stall_out !== (held.size() != 0 && mem_valid_in)) begin
                n_fail++;
                $display("FAIL wb_stall t=%0t: got %b want %b", $time,
                         wb_stall_out, held.size() != 0 && mem_valid_in);
            end
        end
        if (rst_in) begin
            e.chk = 1;
            held.delete();
            mem_taken = 1;
            mdu_taken = 1;
        end else if (held.size() != 0) begin
            h = held.pop_front();
            e.wr = (h.rd != 0);
            e.rd = h.rd;
            e.data = h.data;
        end else if (mem_valid_in) begin
            bad = 0;
            d = mem_alu_result_in;
            if (mem_is_load_in)
                d = ref_load(mem_funct3_in, mem_addr_lsb_in,
                             mem_load_data_in, bad);
            e.fault = bad;
            e.wr = !bad && mem_reg_wr_in && mem_rd_addr_in != 0;
            e.rd = mem_rd_addr_in;
            e.data = d;
            mem_taken = 1;
            if (mdu_valid_in) begin
                mdu_taken = 1;
                if (!(mem_reg_wr_in && mem_rd_addr_in == mdu_rd_addr_in))
                    held.push_back('{rd: mdu_rd_addr_in,
                                     data: mdu_result_in});
            end
        end else if (mdu_valid_in) begin
            e.wr = (mdu_rd_addr_in != 0);
            e.rd = mdu_rd_addr_in;
            e.data = mdu_result_in;
            mdu_taken = 1;
        end
        expq.push_back(e);
        @(negedge clk_in);
        if (mem_taken) mem_valid_in = 0;
        if (mdu_taken) mdu_valid_in = 0;
    endtask

    task automatic mem(input logic [4:0] rd, input logic [31:0] alu,
                       input bit wr, input bit ld, input logic [2:0] f3,
                       input logic [1:0] lsb, input logic [31:0] raw);
        mem_valid_in = 1;
        mem_rd_addr_in = rd;
        mem_alu_result_in = alu;
        mem_reg_wr_in = wr;
        mem_is_load_in = ld;
        mem_funct3_in = f3;
        mem_addr_lsb_in = lsb;
        mem_load_data_in = raw;
    endtask

    task automatic mdu(input logic [4:0] rd, input logic [31:0] res);
        mdu_valid_in = 1;
        mdu_rd_addr_in = rd;
        mdu_result_in = res;
    endtask

    initial begin
        @(negedge clk_in);
        rst_in = 1;
        step();
        chk_comb = 1;
        step();
        rst_in = 0;
        step();

        mem(5, 32'h0, 1, 1, 3'b000, 2, 32'h12803456); step();
        mem(5, 32'h0, 1, 1, 3'b100, 2, 32'h12803456); step();
        mem(6, 32'h0, 1, 1, 3'b001, 2, 32'h80017FFF); step();
        mem(6, 32'h0, 1, 1, 3'b001, 0, 32'h80017FFF); step();
        mem(8, 32'h0, 1, 1, 3'b010, 3, 32'hCAFEF00D); step();
        mem(8, 32'h0, 1, 1, 3'b101, 3, 32'hCAFEF00D); step();

        mem(3, 32'hAAAA0000, 1, 0, 3'b000, 0, 32'h0);
        mdu(7, 32'h1234); step();
        mem(10, 32'h55, 1, 0, 3'b000, 0, 32'h0); step(); step();
        step();

        mem(9, 32'h1, 1, 0, 3'b000, 0, 32'h0);
        mdu(9, 32'h2); step(); step();
        mem(11, 32'h3, 0, 0, 3'b000, 0, 32'h0);
        mdu(11, 32'h4); step(); step();

        mem(0, 32'hDEAD, 1, 0, 3'b000, 0, 32'h0); step();
        mdu(0, 32'hBEEF); step();
        mem(4, 32'h0, 1, 1, 3'b011, 1, 32'hFFFFFFFF); step();
        step();
        mem(4, 32'h0, 1, 1, 3'b111, 1, 32'hFFFFFFFF); step();

        mem(12, 32'h77, 1, 0, 3'b000, 0, 32'h0);
        mdu(13, 32'h99); step();
        rst_in = 1; step();
        rst_in = 0; step(); step();

        for (int i = 0; i < 600; i++) begin
            if (!mem_valid_in && $urandom_range(0, 2) != 0)
                mem(5'($urandom_range(0, 7)), $urandom,
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                    $urandom);
            if (!mdu_valid_in && $urandom_range(0, 1) != 0)
                mdu(5'($urandom_range(0, 7)), $urandom);
            rst_in = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_in = 0;
        mem_valid_in = 0;
        mdu_valid_in = 0;
        repeat (3) step();
        @(posedge clk_in);
        #2;
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
